// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard controller signal bundle
//   ID_rs/ID_rt/ID_UsesRs/ID_UsesRt : register reads of the ID instruction
//   ID_MultiCycle/ID_BranchTaken    : multi-cycle op / taken branch in ID
//   EX_MemRead/EX_rt                : load and its destination in EX
//   PCWrite/IFID_Write/IFID_Flush   : PC and IF/ID register controls
//   IDEX_Bubble/EX_Hold/Busy        : ID/EX register controls, MC status
//   StallCount                      : saturating count of PC-stall cycles
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic             ID_MultiCycle;
  logic             ID_BranchTaken;
  logic             EX_MemRead;
  logic [4:0]       EX_rt;
  logic             PCWrite;
  logic             IFID_Write;
  logic             IFID_Flush;
  logic             IDEX_Bubble;
  logic             EX_Hold;
  logic             Busy;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_MultiCycle, ID_BranchTaken,
           EX_MemRead, EX_rt,
    input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, Busy, StallCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_MultiCycle, ID_BranchTaken,
           EX_MemRead, EX_rt,
    output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EX_Hold, Busy, StallCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use bubble, multi-cycle hold and branch squash control
//   Clk : clock, rising edge
//   Rst : asynchronous active-high reset
//   bus : pipe_hazard_ctrl_if slave (ID/EX inputs in, register enables/clears out)
module pipe_hazard_ctrl #(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input logic              Clk,
  input logic              Rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int MC_W = $clog2(MC_LATENCY + 1);

  typedef enum logic {RUN = 1'b0, MC_EXEC = 1'b1} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [MC_W-1:0]  r_mc_cnt;
  logic [MC_W-1:0]  w_mc_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;

  logic w_pcwrite;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;
  logic w_ex_hold;
  logic w_busy;

  // EX_rt==0 guard keeps writes to r0 from ever looking like a hazard.
  assign w_lu = bus.EX_MemRead && (bus.EX_rt != 5'd0) &&
                ((bus.ID_UsesRs && (bus.ID_rs == bus.EX_rt)) ||
                 (bus.ID_UsesRt && (bus.ID_rt == bus.EX_rt)));

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= RUN;
      r_mc_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_mc_cnt <= w_mc_cnt_next;
      if (!w_pcwrite && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_mc_cnt_next = r_mc_cnt;
    case (r_state)
      RUN: begin
        // A hazard cycle defers the multi-cycle op; it re-presents next cycle.
        if (!w_lu && bus.ID_MultiCycle && (MC_LATENCY > 1)) begin
          w_next_state  = MC_EXEC;
          w_mc_cnt_next = MC_W'(MC_LATENCY - 1);
        end
      end
      MC_EXEC: begin
        w_mc_cnt_next = r_mc_cnt - 1'b1;
        if (r_mc_cnt == MC_W'(1))
          w_next_state = RUN;
      end
      default: begin
        w_next_state  = RUN;
        w_mc_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    w_pcwrite     = 1'b0;
    w_ifid_write  = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_ex_hold     = 1'b0;
    w_busy        = 1'b0;
    if (Rst) begin
      w_idex_bubble = 1'b1;
    end else if (r_state == MC_EXEC) begin
      w_ex_hold = 1'b1;
      w_busy    = 1'b1;
    end else if (w_lu) begin
      w_idex_bubble = 1'b1;
    end else begin
      w_pcwrite    = 1'b1;
      w_ifid_write = 1'b1;
      w_ifid_flush = bus.ID_BranchTaken;
    end
  end

  assign bus.PCWrite     = w_pcwrite;
  assign bus.IFID_Write  = w_ifid_write;
  assign bus.IFID_Flush  = w_ifid_flush;
  assign bus.IDEX_Bubble = w_idex_bubble;
  assign bus.EX_Hold     = w_ex_hold;
  assign bus.Busy        = w_busy;
  assign bus.StallCount  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  pipe_hazard_ctrl_if #(.CNT_W(16)) if_a ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  if_b ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) if_c ();

  pipe_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(16)) u_dut_a (.Clk(Clk), .Rst(Rst), .bus(if_a));
  pipe_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(4))  u_dut_b (.Clk(Clk), .Rst(Rst), .bus(if_b));
  pipe_hazard_ctrl #(.MC_LATENCY(1), .CNT_W(16)) u_dut_c (.Clk(Clk), .Rst(Rst), .bus(if_c));

  assign if_b.ID_rs = if_a.ID_rs;            assign if_c.ID_rs = if_a.ID_rs;
  assign if_b.ID_rt = if_a.ID_rt;            assign if_c.ID_rt = if_a.ID_rt;
  assign if_b.ID_UsesRs = if_a.ID_UsesRs;    assign if_c.ID_UsesRs = if_a.ID_UsesRs;
  assign if_b.ID_UsesRt = if_a.ID_UsesRt;    assign if_c.ID_UsesRt = if_a.ID_UsesRt;
  assign if_b.ID_MultiCycle = if_a.ID_MultiCycle;
  assign if_c.ID_MultiCycle = if_a.ID_MultiCycle;
  assign if_b.ID_BranchTaken = if_a.ID_BranchTaken;
  assign if_c.ID_BranchTaken = if_a.ID_BranchTaken;
  assign if_b.EX_MemRead = if_a.EX_MemRead;  assign if_c.EX_MemRead = if_a.EX_MemRead;
  assign if_b.EX_rt = if_a.EX_rt;            assign if_c.EX_rt = if_a.EX_rt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    if_a.ID_rs = 5'd0; if_a.ID_rt = 5'd0;
    if_a.ID_UsesRs = 1'b0; if_a.ID_UsesRt = 1'b0;
    if_a.ID_MultiCycle = 1'b0; if_a.ID_BranchTaken = 1'b0;
    if_a.EX_MemRead = 1'b0; if_a.EX_rt = 5'd0;
  endtask

  task automatic rs_hazard(input logic [4:0] r);
    if_a.EX_MemRead = 1'b1; if_a.EX_rt = r;
    if_a.ID_rs = r; if_a.ID_UsesRs = 1'b1;
  endtask

  initial begin
    idle();
    // 1: reset values, then first free-running cycle
    #3;
    chk("rst_pcwrite", 32'(if_a.PCWrite), 32'd0);
    chk("rst_ifid_write", 32'(if_a.IFID_Write), 32'd0);
    chk("rst_flush", 32'(if_a.IFID_Flush), 32'd0);
    chk("rst_bubble", 32'(if_a.IDEX_Bubble), 32'd1);
    chk("rst_hold", 32'(if_a.EX_Hold), 32'd0);
    chk("rst_busy", 32'(if_a.Busy), 32'd0);
    chk("rst_stall", 32'(if_a.StallCount), 32'd0);
    Rst = 1'b0;
    tick(); #2;
    chk("run_pcwrite", 32'(if_a.PCWrite), 32'd1);
    chk("run_ifid_write", 32'(if_a.IFID_Write), 32'd1);
    chk("run_busy", 32'(if_a.Busy), 32'd0);

    // 2: single load-use bubble on rs, then clear
    rs_hazard(5'd8); #2;
    chk("lu_pcwrite", 32'(if_a.PCWrite), 32'd0);
    chk("lu_ifid_write", 32'(if_a.IFID_Write), 32'd0);
    chk("lu_bubble", 32'(if_a.IDEX_Bubble), 32'd1);
    chk("lu_flush", 32'(if_a.IFID_Flush), 32'd0);
    tick(); if_a.EX_MemRead = 1'b0; #2;
    chk("lu_after_pcwrite", 32'(if_a.PCWrite), 32'd1);
    chk("lu_after_bubble", 32'(if_a.IDEX_Bubble), 32'd0);
    chk("lu_stall1", 32'(if_a.StallCount), 32'd1);
    // r0 load never stalls
    rs_hazard(5'd0); #2;
    chk("lu_r0_pcwrite", 32'(if_a.PCWrite), 32'd1);
    // rt match with UsesRt=0 is not a hazard, with UsesRt=1 it is
    tick(); idle();
    if_a.EX_MemRead = 1'b1; if_a.EX_rt = 5'd5; if_a.ID_rt = 5'd5; #2;
    chk("rt_unused_pcwrite", 32'(if_a.PCWrite), 32'd1);
    if_a.ID_UsesRt = 1'b1; #1;
    chk("rt_lu_pcwrite", 32'(if_a.PCWrite), 32'd0);
    tick(); idle(); #2;
    chk("rt_stall2", 32'(if_a.StallCount), 32'd2);

    // 3: multi-cycle op, latency 4 -> 3 hold cycles
    if_a.ID_MultiCycle = 1'b1; #2;
    chk("mc_issue_pcwrite", 32'(if_a.PCWrite), 32'd1);
    chk("mc_issue_busy", 32'(if_a.Busy), 32'd0);
    tick(); if_a.ID_MultiCycle = 1'b0; #2;
    chk("mc1_hold", 32'(if_a.EX_Hold), 32'd1);
    chk("mc1_busy", 32'(if_a.Busy), 32'd1);
    chk("mc1_pcwrite", 32'(if_a.PCWrite), 32'd0);
    chk("mc1_lat1_busy", 32'(if_c.Busy), 32'd0);
    chk("mc1_lat1_pcwrite", 32'(if_c.PCWrite), 32'd1);
    tick(); #2;
    chk("mc2_busy", 32'(if_a.Busy), 32'd1);
    tick(); #2;
    chk("mc3_busy", 32'(if_a.Busy), 32'd1);
    chk("mc3_ifid_write", 32'(if_a.IFID_Write), 32'd0);
    tick(); #2;
    chk("mc_done_busy", 32'(if_a.Busy), 32'd0);
    chk("mc_done_pcwrite", 32'(if_a.PCWrite), 32'd1);
    chk("mc_stall5", 32'(if_a.StallCount), 32'd5);
    chk("mc_lat1_stall2", 32'(if_c.StallCount), 32'd2);

    // 4: hazard outranks branch and multi-cycle
    rs_hazard(5'd8); if_a.ID_MultiCycle = 1'b1; if_a.ID_BranchTaken = 1'b1; #2;
    chk("pri_bubble", 32'(if_a.IDEX_Bubble), 32'd1);
    chk("pri_flush", 32'(if_a.IFID_Flush), 32'd0);
    chk("pri_pcwrite", 32'(if_a.PCWrite), 32'd0);
    tick(); if_a.EX_MemRead = 1'b0; #2;
    chk("pri_no_mc_busy", 32'(if_a.Busy), 32'd0);
    chk("pri_flush_next", 32'(if_a.IFID_Flush), 32'd1);
    chk("pri_pcwrite_next", 32'(if_a.PCWrite), 32'd1);
    tick(); if_a.ID_MultiCycle = 1'b0; #2;
    chk("pri_mc_busy", 32'(if_a.Busy), 32'd1);
    chk("pri_mc_flush_ignored", 32'(if_a.IFID_Flush), 32'd0);
    tick(); #2;

    // 5: async reset in the second MC_EXEC cycle
    chk("mc2b_busy", 32'(if_a.Busy), 32'd1);
    chk("mc2b_stall7", 32'(if_a.StallCount), 32'd7);
    idle();
    Rst = 1'b1; #1;
    chk("arst_busy", 32'(if_a.Busy), 32'd0);
    chk("arst_hold", 32'(if_a.EX_Hold), 32'd0);
    chk("arst_bubble", 32'(if_a.IDEX_Bubble), 32'd1);
    chk("arst_stall", 32'(if_a.StallCount), 32'd0);
    Rst = 1'b0;
    tick(); #2;
    chk("arst_after_busy", 32'(if_a.Busy), 32'd0);
    chk("arst_after_pcwrite", 32'(if_a.PCWrite), 32'd1);
    chk("arst_after_stall", 32'(if_a.StallCount), 32'd0);

    // 6: 20 held hazard cycles, 4-bit counter saturates without wrapping
    rs_hazard(5'd3);
    for (int i = 0; i < 20; i++) tick();
    #2;
    chk("sat_pcwrite", 32'(if_a.PCWrite), 32'd0);
    chk("sat_wide20", 32'(if_a.StallCount), 32'd20);
    chk("sat_narrow15", 32'(if_b.StallCount), 32'd15);
    tick(); #2;
    chk("sat_narrow_hold", 32'(if_b.StallCount), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
